// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry, pixel/row types and frame-store states.
// Used by the frame store and the matrix scanner.
package matrix_pkg;

  localparam int MATRIX_W   = 16;
  localparam int MATRIX_H   = 16;
  localparam int MATRIX_BPP = 2;

  typedef logic [MATRIX_BPP-1:0]          pix_t;
  typedef logic [MATRIX_W*MATRIX_BPP-1:0] row_t;
  typedef logic [$clog2(MATRIX_W)-1:0]    col_t;
  typedef logic [$clog2(MATRIX_H)-1:0]    lin_t;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_CLEAR,
    FS_PENDING
  } fs_state_t;

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one 16-row pixel bank with per-pixel write,
// single-row clear and combinational row read.
module fb_bank
  import matrix_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  col_t wx,
  input  lin_t wy,
  input  pix_t wpix,
  input  logic clr,
  input  lin_t clr_row,
  input  lin_t rd_row,
  output row_t rd_data
);

  row_t mem [MATRIX_H];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MATRIX_H; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (clr) begin
        mem[clr_row] <= '0;
      end
      if (we) begin
        mem[wy][{wx, 1'b0} +: MATRIX_BPP] <= wpix;
      end
    end
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/matrix_frame_store.sv
// matrix_frame_store: double-buffered 16x16x2b pixel store.
// Back bank is drawn into; swap waits for the scanner's frame_start.
module matrix_frame_store
  import matrix_pkg::*;
#(
  parameter int W   = MATRIX_W,
  parameter int H   = MATRIX_H,
  parameter int BPP = MATRIX_BPP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [$clog2(W)-1:0] wr_x,
  input  logic [$clog2(H)-1:0] wr_y,
  input  logic [BPP-1:0]       wr_pix,
  input  logic                 clr_req,
  input  logic                 swap_req,
  output logic                 swap_pending,
  input  logic                 frame_start,
  output logic                 front_sel,
  input  logic [$clog2(H)-1:0] rd_row,
  output logic [W*BPP-1:0]     rd_data
);

  fs_state_t state, state_nxt;
  lin_t      clr_cnt, clr_cnt_nxt;
  logic      front_nxt;
  logic      wr_fire;
  logic      clearing;
  row_t      rd0, rd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      clr_cnt   <= '0;
      front_sel <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      front_sel <= front_nxt;
    end
  end

  // frame_start is only looked at in PENDING, so a swap
  // requested on a frame_start cycle waits for the next one
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    front_nxt   = front_sel;
    unique case (state)
      FS_IDLE: begin
        if (swap_req) begin
          state_nxt = FS_PENDING;
        end else if (clr_req) begin
          state_nxt = FS_CLEAR;
        end
      end
      FS_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == lin_t'(H - 1)) begin
          state_nxt = FS_IDLE;
        end
      end
      FS_PENDING: begin
        if (frame_start) begin
          state_nxt = FS_IDLE;
          front_nxt = ~front_sel;
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  assign wr_ready     = (state == FS_IDLE);
  assign swap_pending = (state == FS_PENDING);
  assign clearing     = (state == FS_CLEAR);
  assign wr_fire      = wr_valid && wr_ready;

  fb_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_fire && front_sel),
    .wx      (wr_x),
    .wy      (wr_y),
    .wpix    (wr_pix),
    .clr     (clearing && front_sel),
    .clr_row (clr_cnt),
    .rd_row  (rd_row),
    .rd_data (rd0)
  );

  fb_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_fire && !front_sel),
    .wx      (wr_x),
    .wy      (wr_y),
    .wpix    (wr_pix),
    .clr     (clearing && !front_sel),
    .clr_row (clr_cnt),
    .rd_row  (rd_row),
    .rd_data (rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= front_sel ? rd1 : rd0;
    end
  end

endmodule

// File: tb/tb_matrix_frame_store.sv
// tb_matrix_frame_store: scoreboard bench with a pixel-level
// reference model of both buffers, swap and clear behaviour.
module tb_matrix_frame_store;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_x = '0;
  logic [3:0]  wr_y = '0;
  logic [1:0]  wr_pix = '0;
  logic        clr_req = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        frame_start = 1'b0;
  logic        front_sel;
  logic [3:0]  rd_row = '0;
  logic [31:0] rd_data;

  matrix_frame_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_pix       (wr_pix),
    .clr_req      (clr_req),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .front_sel    (front_sel),
    .rd_row       (rd_row),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        rdy;
    logic        pend;
    logic        fsel;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  // reference model: pixel arrays, displayed bank, busy countdown
  int m_pix [2][16][16];
  int m_front = 0;
  int m_busy  = 0;
  bit m_pend  = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [31:0] m_row(int b, int r);
    logic [31:0] v = '0;
    for (int x = 0; x < 16; x++) v[2*x +: 2] = 2'(m_pix[b][r][x]);
    return v;
  endfunction

  function automatic void m_zero(int b);
    for (int r = 0; r < 16; r++)
      for (int x = 0; x < 16; x++) m_pix[b][r][x] = 0;
  endfunction

  function automatic void model_step();
    exp_t e;
    int   bk = 1 - m_front;
    if (!rst_n) begin
      m_zero(0);
      m_zero(1);
      m_front = 0;
      m_busy  = 0;
      m_pend  = 0;
      e.data  = '0;
    end else begin
      e.data = m_row(m_front, int'(rd_row));
      if (m_busy == 0 && !m_pend) begin
        if (wr_valid) m_pix[bk][wr_y][wr_x] = int'(wr_pix);
        if (swap_req) m_pend = 1;
        else if (clr_req) begin
          m_zero(bk);
          m_busy = 16;
        end
      end else if (m_busy > 0) begin
        m_busy--;
      end else if (frame_start) begin
        m_pend  = 0;
        m_front = bk;
      end
    end
    e.rdy  = (m_busy == 0 && !m_pend);
    e.pend = m_pend;
    e.fsel = m_front[0];
    q.push_back(e);
  endfunction

  task automatic tick();
    model_step();
    @(negedge clk);
    wr_valid    = 1'b0;
    swap_req    = 1'b0;
    clr_req     = 1'b0;
    frame_start = 1'b0;
    wr_x   = 4'($urandom_range(0, 15));
    wr_y   = 4'($urandom_range(0, 15));
    wr_pix = 2'($urandom_range(0, 3));
    rd_row = 4'($urandom_range(0, 15));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
        chk("swap_pending", 32'(swap_pending), 32'(e.pend));
        chk("front_sel", 32'(front_sel), 32'(e.fsel));
      end
    end
  end

  initial begin
    int lowc;
    repeat (3) tick();
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // write (3,5)=2 then swap it to the front
    wr_valid = 1'b1; wr_x = 4'd3; wr_y = 4'd5; wr_pix = 2'd2;
    tick();
    swap_req = 1'b1;
    tick();
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    rd_row = 4'd5;
    tick();
    chk("swap_row5", rd_data, 32'h0000_0080);
    chk("swap_front", 32'(front_sel), 32'd1);
    rd_row = 4'd4;
    tick();
    chk("swap_row4", rd_data, 32'h0);

    // stalled swap with writes that must be ignored
    swap_req = 1'b1;
    tick();
    repeat (100) begin
      wr_valid = 1'b1;
      tick();
    end
    chk("stall_ready", 32'(wr_ready), 32'd0);
    chk("stall_pending", 32'(swap_pending), 32'd1);
    frame_start = 1'b1;
    tick();
    chk("stall_done_ready", 32'(wr_ready), 32'd1);
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      tick();
    end

    // same-cycle swap_req and frame_start
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    chk("same_front", 32'(front_sel), 32'd0);
    repeat (2) tick();
    frame_start = 1'b1;
    tick();
    chk("same_next_front", 32'(front_sel), 32'd1);

    // fill back bank with 3, clear, watch front row 5
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) begin
        wr_valid = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_pix = 2'd3;
        tick();
      end
    clr_req = 1'b1;
    tick();
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wr_ready) lowc++;
      rd_row = 4'd5;
      tick();
      if (i < 15) chk("clear_front_row5", rd_data, 32'h0000_0080);
    end
    chk("clear_len", 32'(lowc), 32'd16);
    swap_req = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      tick();
      chk("cleared_row", rd_data, 32'h0);
    end

    // reset in the middle of a clear
    repeat (10) begin
      wr_valid = 1'b1; wr_pix = 2'd3;
      tick();
    end
    clr_req = 1'b1;
    tick();
    repeat (6) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("midclr_ready", 32'(wr_ready), 32'd1);
    chk("midclr_front", 32'(front_sel), 32'd0);
    chk("midclr_rd", rd_data, 32'h0);
    rst_n = 1'b1;
    tick();
    swap_req = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      rd_row = 4'(r);
      tick();
      chk("post_reset_row", rd_data, 32'h0);
    end

    // random traffic
    repeat (1500) begin
      wr_valid    = ($urandom_range(0, 1) == 1);
      swap_req    = ($urandom_range(0, 19) == 0);
      clr_req     = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
